// File: rtl/systolic_pkg.sv
// Shared constants and FSM encoding for the systolic array result path.
package systolic_pkg;

    localparam int DIMENSION = 4;
    localparam int I_BITS    = 8;
    localparam int O_BITS    = (2 * I_BITS) + $clog2(DIMENSION);
    localparam int NUM_PE    = DIMENSION * DIMENSION;
    localparam int IDX_BITS  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_STREAM = 2'd3
    } drain_state_e;

endpackage

// File: rtl/systolic_drain_buffer.sv
// Snapshot register array for all PE results, loaded in one cycle and read
// back one word at a time by index.
module systolic_drain_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 18,
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [DEPTH*WIDTH-1:0] wr_flat,
    input  logic [IDX_W-1:0]       rd_index,
    output logic [WIDTH-1:0]       rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= wr_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    assign rd_data = mem_q[rd_index];

endmodule

// File: rtl/systolic_result_drain.sv
// Arms the PE grid, waits for every finish flag, snapshots the results and
// streams them row-major on valid/ready. Optional WAIT watchdog: DRAIN_TIMEOUT_EN.
module systolic_result_drain #(
    parameter int  DIMENSION      = systolic_pkg::DIMENSION,
    parameter int  I_BITS         = systolic_pkg::I_BITS,
    parameter int  O_BITS         = (2 * I_BITS) + $clog2(DIMENSION),
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int NUM_PE         = DIMENSION * DIMENSION,
    localparam int IDX_W          = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    i_start,
    input  logic [NUM_PE*O_BITS-1:0] i_c_flat,
    input  logic [NUM_PE-1:0]       i_finish_flat,
    output logic                    o_array_clear,
    output logic [O_BITS-1:0]       o_data,
    output logic [IDX_W-1:0]        o_index,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_last,
    output logic                    o_busy,
    output logic                    o_timeout,
    output logic [1:0]              o_state
);

    import systolic_pkg::*;

    // Valid/ready: o_valid is decoded from the STREAM state only and never
    // looks at i_ready; data/index/last are held until o_valid && i_ready.
    drain_state_e      state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [O_BITS-1:0] rd_data;
    logic              all_finish;
    logic              last_word;
    logic              load;
    logic              timeout_hit;

    assign all_finish = &i_finish_flat;
    assign last_word  = (index_q == IDX_W'(NUM_PE - 1));

    systolic_drain_buffer #(
        .DEPTH (NUM_PE),
        .WIDTH (O_BITS),
        .IDX_W (IDX_W)
    ) u_buffer (
        .clk      (i_clock),
        .rst_n    (i_reset_n),
        .load     (load),
        .wr_flat  (i_c_flat),
        .rd_index (index_q),
        .rd_data  (rd_data)
    );

`ifdef DRAIN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_q;

    assign timeout_hit = (state_q == ST_WAIT) && !all_finish &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside WAIT, so every entry into WAIT starts from zero.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state_q == ST_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (all_finish) begin
                    load    = 1'b1;
                    index_d = '0;
                    state_d = ST_STREAM;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (i_ready) begin
                    // Index returns to zero on exit so o_index idles at 0.
                    if (last_word) begin
                        index_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_array_clear = (state_q == ST_CLEAR);
    assign o_valid       = (state_q == ST_STREAM);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_index       = index_q;
    assign o_last        = o_valid && last_word;
    assign o_data        = o_valid ? rd_data : '0;
    assign o_state       = state_q;

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Result collector for the DIMENSION×DIMENSION systolic multiplier array. It arms a run by pulsing a synchronous clear into the PE grid. It then waits until every PE reports its finish flag, snapshots all accumulated products in a single cycle, and streams them out row-major on a valid/ready interface. It is the read-side counterpart of the PE grid and sits between the array and the host/UART output path.

## Interface
Parameters:
- DIMENSION, 4, array side length; the array holds DIMENSION² PEs.
- I_BITS, 8, PE operand width.
- O_BITS, (2*I_BITS)+$clog2(DIMENSION), PE accumulator width (18 at defaults).
- TIMEOUT_CYCLES, 64, watchdog limit for the WAIT state; used only with DRAIN_TIMEOUT_EN.

Ports:
- i_clock  in  1  single clock; all logic on its rising edge.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_start  in  1  arm request; sampled only in IDLE.
- i_c_flat  in  DIMENSION²·O_BITS  PE results; PE(r,c) occupies slice idx=r·DIMENSION+c, bits [(idx+1)·O_BITS-1 : idx·O_BITS].
- i_finish_flat  in  DIMENSION²  PE finish flags, same index order.
- o_array_clear  out  1  active-high synchronous clear to the PE grid and the operand feeder.
- o_data  out  O_BITS  current result word.
- o_index  out  $clog2(DIMENSION²)  index of o_data.
- o_valid  out  1  o_data/o_index valid.
- i_ready  in  1  downstream accepts the word.
- o_last  out  1  high with the final word (idx = DIMENSION²-1).
- o_busy  out  1  high in every state except IDLE.
- o_timeout  out  1  one-cycle watchdog pulse; constant 0 without DRAIN_TIMEOUT_EN.

## Operation
- FSM states: IDLE → CLEAR → WAIT → STREAM → IDLE.
- IDLE: outputs quiescent. If i_start = 1, go to CLEAR.
- CLEAR: lasts exactly 1 cycle with o_array_clear = 1. PE counters reset on the edge that leaves CLEAR, so stale finish flags from the previous run are never observed. Then go to WAIT.
- WAIT: when &i_finish_flat = 1, capture all DIMENSION² words of i_c_flat into the internal buffer on that edge, clear the read index to 0, and go to STREAM.
- STREAM:
  - o_valid = 1, o_data = buf[index], o_index = index.
  - Each cycle with o_valid && i_ready, index increments.
  - On the handshake where o_last = 1, go to IDLE.
- Buffer contents are frozen for the whole STREAM state; changes on i_c_flat are ignored.
- i_start is ignored outside IDLE. i_start held high at the last STREAM handshake is not seen until the following IDLE cycle.
- Partial finish, i.e. any flag still 0, keeps the FSM in WAIT.

## Timing
- Reset: asynchronous. State = IDLE, index = 0, buffer = 0. Every output is 0 (o_array_clear, o_data, o_index, o_valid, o_last, o_busy, o_timeout).
- Reset asserted mid-operation aborts immediately. No partial stream resumes after release.
- i_start high in cycle T:
  - o_array_clear and o_busy are high in cycle T+1.
  - The FSM is in WAIT from T+2.
- All finish flags seen in cycle N: o_valid rises in cycle N+1, holding word 0.
- With i_ready held at 1: one word per cycle, so DIMENSION² consecutive valid cycles, then o_busy = 0 in the next cycle.
- Valid/ready rules:
  - Once o_valid is high, o_data, o_index and o_last stay stable until the handshake.
  - o_valid never drops without a handshake.
  - o_valid does not depend combinationally on i_ready.
- All outputs are registered or decoded from state/index registers only. There is no combinational path from any input to any output.

## Configuration
- DRAIN_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT and is cleared on entry.
  - If it reaches TIMEOUT_CYCLES with &i_finish_flat still 0, o_timeout pulses for 1 cycle, the FSM returns to IDLE, and nothing is streamed.
- DRAIN_TIMEOUT_EN undefined: no counter is built, WAIT lasts indefinitely, and o_timeout is tied to 0.

## Structure
- Shared package systolic_pkg holds:
  - DIMENSION, I_BITS, O_BITS;
  - the index width localparam;
  - the state encoding (IDLE=0, CLEAR=1, WAIT=2, STREAM=3).
- One sub-module, systolic_drain_buffer: a DIMENSION²×O_BITS capture register array with a load strobe and an index-addressed read mux.
- The FSM, index and watchdog stay in the top level.

## Test plan
- Nominal, DIMENSION=4:
  - Stimulus: preload i_c_flat with value = 100+idx, raise all finish flags 5 cycles after the clear, i_ready=1.
  - Response: 16 words 100..115, o_index 0..15, o_last only on 115, o_busy low the cycle after.
- Backpressure: toggle i_ready 1,0,0,1 repeatedly → no word lost or duplicated; o_data held during ready=0.
- Partial finish: 15 of 16 flags set for 40 cycles, then the last one set → no o_valid before the last flag; the stream starts the next cycle.
- Snapshot: change i_c_flat to all-ones during STREAM → the streamed words still equal the captured 100+idx values.
- Reset mid-stream: assert i_reset_n=0 after word 6 → all outputs 0 immediately; a new i_start yields a clean 16-word run starting at index 0.
- With DRAIN_TIMEOUT_EN and TIMEOUT_CYCLES=64, finish never set → o_timeout pulses exactly once, state returns to IDLE, o_valid never asserts.
